regfile_sb: RTL and testbench

Parametrised multi-read-port register file with an integrated busy-bit scoreboard, for the decode stage of the pipelined core. It generalises the 2-read/1-write 32×32 file to configurable width, depth and read-port count. It adds write-to-read bypass and per-register pending-write tracking, so decode can detect RAW hazards on long-latency results without a separate hazard table. Register 0 is hardwired to zero.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/rf_read_port.sv | 37 +++
 rtl/regfile_sb.sv | 75 +++++++
 tb/tb_regfile_sb.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the decode-stage register file with busy-bit scoreboard.
`timescale 1ns/1ps
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 2;
    localparam int ZERO_REG = 0;

    typedef logic [$clog2(NREG_DEF)-1:0] rf_addr_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: zero-register check, stored lookup, and
// write-to-read bypass for both data and busy.
`timescale 1ns/1ps
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int  XLEN = XLEN_DEF,
    parameter int  NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            active,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] entries [NREG],
    input  logic [NREG-1:0] busy_vec,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] data,
    output logic            busy
);

    // An in-flight write completes the pending result, so it also hides the busy bit.
    always_comb begin
        data = '0;
        busy = 1'b0;
        if (active && addr != AW'(ZERO_REG)) begin
            if (we && wa == addr) begin
                data = wd;
                busy = 1'b0;
            end else begin
                data = entries[addr];
                busy = busy_vec[addr];
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with per-register pending-write scoreboard;
// register 0 is hardwired to zero and never marked busy.
`timescale 1ns/1ps
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int  XLEN = XLEN_DEF,
    parameter int  NREG = NREG_DEF,
    parameter int  NRD  = NRD_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [XLEN-1:0]   wd,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    output logic [AW:0]       busy_cnt
);

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     cnt_nxt;

    // Reserve is applied after the write-clear so a younger reservation wins a collision.
    always_comb begin
        busy_nxt = busy;
        if (we && wa != AW'(ZERO_REG))
            busy_nxt[wa] = 1'b0;
        if (rsv_en && rsv_addr != AW'(ZERO_REG))
            busy_nxt[rsv_addr] = 1'b1;
        busy_nxt[ZERO_REG] = 1'b0;
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++)
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++)
                mem[i] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (we && wa != AW'(ZERO_REG))
                mem[wa] <= wd;
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // Reset gates the ports so a bypassed write cannot leak out while reset is held.
    for (genvar k = 0; k < NRD; k++) begin : g_port
        rf_read_port #(
            .XLEN (XLEN),
            .NREG (NREG)
        ) u_port (
            .active   (rst),
            .addr     (rd_addr[k*AW +: AW]),
            .entries  (mem),
            .busy_vec (busy),
            .we       (we),
            .wa       (wa),
            .wd       (wd),
            .data     (rd_data[k*XLEN +: XLEN]),
            .busy     (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb with four read ports: directed vector
// table, hand-written reset sequence, and randomized traffic against a model.
`timescale 1ns/1ps
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int NP = 4;

    logic            clk;
    logic            rst;
    logic [NP*5-1:0] rd_addr;
    logic [NP*32-1:0] rd_data;
    logic [NP-1:0]   rd_busy;
    logic            we;
    rf_addr_t        wa;
    logic [31:0]     wd;
    logic            rsv_en;
    rf_addr_t        rsv_addr;
    logic [5:0]      busy_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem  [32];
    bit          ref_busy [32];

    typedef struct packed {
        logic              w;
        rf_addr_t          a;
        logic [31:0]       d;
        logic              r;
        rf_addr_t          ra;
        logic [3:0][4:0]   p;
        logic [3:0][31:0]  ed;
        logic [3:0]        eb;
        logic [5:0]        ec;
    } vec_t;

    vec_t vecs [14];

    regfile_sb #(.XLEN(32), .NREG(32), .NRD(NP)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic w, input int a, input logic [31:0] d,
                                input logic r, input int ra,
                                input int p0, input int p1, input int p2, input int p3,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3,
                                input logic [3:0] eb, input int ec);
        vec_t v;
        v.w  = w;  v.a = rf_addr_t'(a); v.d = d;
        v.r  = r;  v.ra = rf_addr_t'(ra);
        v.p  = {5'(p3), 5'(p2), 5'(p1), 5'(p0)};
        v.ed = {e3, e2, e1, e0};
        v.eb = eb;
        v.ec = 6'(ec);
        return v;
    endfunction

    function automatic logic [31:0] model_data(input int a);
        if (!rst || a == 0) return 32'd0;
        if (we && int'(wa) == a) return wd;
        return ref_mem[a];
    endfunction

    function automatic logic model_busy(input int a);
        if (!rst || a == 0) return 1'b0;
        if (we && int'(wa) == a) return 1'b0;
        return ref_busy[a];
    endfunction

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(ref_busy[i]);
        return c;
    endfunction

    function automatic int rand_addr();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 31));
        return int'($urandom_range(0, 7));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            ref_mem[i]  = 32'd0;
            ref_busy[i] = 1'b0;
        end
    endtask

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic w, input int a, input logic [31:0] d,
                                 input logic r, input int ra,
                                 input int p0, input int p1, input int p2, input int p3);
        @(negedge clk);
        we       = w;
        wa       = rf_addr_t'(a);
        wd       = d;
        rsv_en   = r;
        rsv_addr = rf_addr_t'(ra);
        rd_addr  = {5'(p3), 5'(p2), 5'(p1), 5'(p0)};
        #1;
    endtask

    task automatic checkOutput(input string tag);
        for (int k = 0; k < NP; k++) begin
            compare($sformatf("%s data%0d", tag, k), rd_data[k*32 +: 32],
                    model_data(int'(rd_addr[k*5 +: 5])));
            compare($sformatf("%s busy%0d", tag, k), {31'd0, rd_busy[k]},
                    {31'd0, model_busy(int'(rd_addr[k*5 +: 5]))});
        end
        compare($sformatf("%s busy_cnt", tag), {26'd0, busy_cnt}, 32'(model_cnt()));
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            if (we && wa != 0) begin
                ref_mem[wa]  = wd;
                ref_busy[wa] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) ref_busy[rsv_addr] = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; wa = '0; wd = '0;
        rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
        model_reset();

        #2;
        checkOutput("reset");
        #10;
        rst = 1'b1;

        vecs[0]  = mk(1, 7, 32'h12345678, 0, 0,  7, 0, 7, 1,
                      32'h12345678, 0, 32'h12345678, 0, 4'b0000, 0);
        vecs[1]  = mk(0, 0, 0, 1, 3,  7, 3, 0, 0,
                      32'h12345678, 0, 0, 0, 4'b0000, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0,  3, 7, 3, 0,
                      0, 32'h12345678, 0, 0, 4'b0101, 1);
        vecs[3]  = mk(0, 0, 0, 0, 0,  3, 7, 3, 0,
                      0, 32'h12345678, 0, 0, 4'b0101, 1);
        vecs[4]  = mk(1, 3, 32'hCAFE0003, 0, 0,  3, 3, 7, 0,
                      32'hCAFE0003, 32'hCAFE0003, 32'h12345678, 0, 4'b0000, 1);
        vecs[5]  = mk(0, 0, 0, 0, 0,  3, 0, 0, 0,
                      32'hCAFE0003, 0, 0, 0, 4'b0000, 0);
        vecs[6]  = mk(1, 0, 32'hFFFFFFFF, 1, 0,  0, 0, 0, 0,
                      0, 0, 0, 0, 4'b0000, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,
                      0, 0, 0, 0, 4'b0000, 0);
        vecs[8]  = mk(0, 0, 0, 1, 9,  9, 0, 0, 0,
                      0, 0, 0, 0, 4'b0000, 0);
        vecs[9]  = mk(1, 9, 32'h000000A5, 1, 9,  9, 0, 0, 0,
                      32'h000000A5, 0, 0, 0, 4'b0000, 1);
        vecs[10] = mk(0, 0, 0, 0, 0,  9, 0, 0, 0,
                      32'h000000A5, 0, 0, 0, 4'b0001, 1);
        vecs[11] = mk(1, 1, 32'h11111111, 0, 0,  1, 0, 0, 0,
                      32'h11111111, 0, 0, 0, 4'b0000, 1);
        vecs[12] = mk(1, 2, 32'h22222222, 0, 0,  1, 2, 1, 0,
                      32'h11111111, 32'h22222222, 32'h11111111, 0, 4'b0000, 1);
        vecs[13] = mk(0, 0, 0, 0, 0,  2, 9, 1, 0,
                      32'h22222222, 32'h000000A5, 32'h11111111, 0, 4'b0010, 1);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].w, int'(vecs[i].a), vecs[i].d, vecs[i].r, int'(vecs[i].ra),
                          int'(vecs[i].p[0]), int'(vecs[i].p[1]),
                          int'(vecs[i].p[2]), int'(vecs[i].p[3]));
            for (int k = 0; k < NP; k++) begin
                compare($sformatf("vec%0d data%0d", i, k), rd_data[k*32 +: 32], vecs[i].ed[k]);
                compare($sformatf("vec%0d busy%0d", i, k), {31'd0, rd_busy[k]}, {31'd0, vecs[i].eb[k]});
            end
            compare($sformatf("vec%0d busy_cnt", i), {26'd0, busy_cnt}, {26'd0, vecs[i].ec});
            advance();
        end

        // Mid-cycle reset discards stored data and reservations immediately.
        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0,  5, 9, 0, 0);
        checkOutput("pre-reset");
        advance();
        applyStimulus(1, 6, 32'h00000066, 1, 4,  5, 9, 6, 4);
        checkOutput("stored r5");
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        compare("async reset r5", rd_data[31:0], 32'd0);
        compare("async reset bypass r6", rd_data[95:64], 32'd0);
        compare("async reset busy", {28'd0, rd_busy}, 32'd0);
        compare("async reset busy_cnt", {26'd0, busy_cnt}, 32'd0);
        advance();
        applyStimulus(1, 5, 32'h00000077, 1, 8,  5, 8, 9, 0);
        checkOutput("held reset");
        advance();
        applyStimulus(1, 5, 32'h00000055, 1, 8,  5, 8, 6, 0);
        rst = 1'b1;
        #1;
        checkOutput("release");
        advance();
        applyStimulus(0, 0, 0, 0, 0,  5, 8, 6, 9);
        checkOutput("first edge");
        compare("first edge r5", rd_data[31:0], 32'h00000055);
        compare("first edge busy_cnt", {26'd0, busy_cnt}, 32'd1);
        advance();

        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 1) == 1, rand_addr(), $urandom,
                          $urandom_range(0, 2) == 0, rand_addr(),
                          rand_addr(), rand_addr(), rand_addr(), rand_addr());
            checkOutput($sformatf("rand%0d", n));
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
